sequence_rng_memory: RTL and testbench
======================================

Name: sequence_rng_memory

Overview:
- Upstream stage of the game controller: generates the SEQ_LEN-entry random symbol sequence on request_seq and stores it in internal memory.
- Shows the sequence one symbol at a time on the display interface, then asserts sequence_done.
- On request_Q, picks a pseudo-random stored entry and returns it as rand_Q, the question the players must match.
- Output timing matches the controller's REQUEST→COMPUTATIONAL and WAIT_STATE_2→FETCH timing.

Parameters:
- SEQ_LEN, 5, number of stored symbols (2..8).
- DATA_W, 3, symbol width.
- IDX_W, 3, index width. Constraint: SEQ_LEN <= 2^IDX_W <= 2*SEQ_LEN.
- SHOW_CYCLES, 50000000, clock cycles each symbol is displayed (>=1).
- SEED, 16'hACE1, LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- request_seq  in  1  level; high requests generation and display of a new sequence.
- request_Q  in  1  single-cycle pulse; requests a question symbol.
- sequence_done  out  1  high when the sequence has been generated and shown.
- rand_Q  out  DATA_W  question symbol.
- q_valid  out  1  one-cycle pulse when rand_Q is updated.
- q_idx  out  IDX_W  memory index of the current rand_Q.
- disp_en  out  1  high while a symbol is being shown.
- disp_idx  out  IDX_W  position of the shown symbol.
- disp_val  out  DATA_W  shown symbol.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE, lfsr=SEED.
  - mem[0..SEQ_LEN-1]=0, wr_idx=0, hold_cnt=0.
  - All outputs 0.
  - Reset takes priority over everything, mid-operation included.
- LFSR:
  - 16-bit Galois, shifts right every non-reset cycle regardless of state.
  - If lsb=1, the next value is (lfsr>>1)^16'hB400; otherwise lfsr>>1.
  - Never reaches 0.
- Index reduction: v=lfsr[IDX_W-1:0]; idx = v if v<SEQ_LEN, else v-SEQ_LEN.
- States: IDLE, GEN, SHOW, DONE.
- IDLE:
  - If request_seq==1, go to GEN with wr_idx=0.
  - sequence_done=0, disp_en=0.
- GEN:
  - Each cycle writes mem[wr_idx]=lfsr[DATA_W-1:0] and increments wr_idx.
  - After writing index SEQ_LEN-1: go to SHOW with disp_idx=0, disp_val=mem[0] (the value just written to index 0), disp_en=1, hold_cnt=0.
- SHOW:
  - hold_cnt counts 0..SHOW_CYCLES-1.
  - At terminal count with disp_idx<SEQ_LEN-1: disp_idx++, disp_val=mem[disp_idx+1], hold_cnt=0.
  - At terminal count with disp_idx==SEQ_LEN-1: disp_en=0, sequence_done=1, go to DONE.
- DONE:
  - sequence_done stays 1 while request_seq==1.
  - When request_seq==0: sequence_done=0 on the next edge, go to IDLE.
- Abort: request_seq==0 seen in GEN or SHOW:
  - Next edge goes to IDLE with disp_en=0 and sequence_done=0.
  - Partially written memory is kept; no clearing.
- Latency: request_seq first sampled high at edge E0 → sequence_done high after edge E0+SEQ_LEN+SEQ_LEN*SHOW_CYCLES.
- Question path:
  - request_Q is sampled only in IDLE and DONE; ignored in GEN and SHOW.
  - On a sampled request_Q at edge E: q_idx=idx, rand_Q=mem[idx], q_valid=1, all at E (1-cycle latency, registered).
  - q_valid drops at E+1 unless request_Q is still high.
  - rand_Q and q_idx hold until the next served request or reset.
- Simultaneous request_seq and request_Q in IDLE: both are acted on. The question read returns pre-GEN (old) memory contents; the state moves to GEN.
- request_Q held high for several cycles in IDLE/DONE: a new pick is made every cycle and q_valid stays high. Legal; the controller only pulses it.

Test Plan:
- Reset → all outputs 0 and lfsr==16'hACE1. Then hold rst low 3 cycles mid-SHOW → state IDLE, disp_en=0, mem all 0.
- SHOW_CYCLES=4, SEQ_LEN=5, request_seq raised at E0 and held →
  - mem contents match the bit-exact reference LFSR model (lfsr[2:0] at cycles E1..E5).
  - disp_idx steps 0,1,2,3,4, each held 4 cycles; disp_en high E5..E25.
  - sequence_done rises after E25.
  - Drop request_seq → sequence_done 0 one edge later.
- In DONE, pulse request_Q at edge E → at E:
  - q_valid=1 for one cycle.
  - q_idx equals the model-computed index; check the wrap case v=6 → idx=1.
  - rand_Q=mem[q_idx].
- request_Q pulsed during GEN and during SHOW → q_valid stays 0; rand_Q and q_idx unchanged.
- request_seq dropped during SHOW at disp_idx=2 → IDLE next edge, sequence_done never rises. A re-request regenerates all 5 entries.
- request_seq and request_Q asserted in the same IDLE cycle → rand_Q returns the old mem value; GEN starts on the same edge.

Source files
------------

// File: rtl/sequence_rng_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : sequence_rng_memory_if
// Description : Bus between the game controller and the sequence/RNG memory
//               stage. It carries the request strobes from the controller and
//               the display and question results back to it.
//               master : controller side (drives request_seq, request_Q)
//               slave  : sequence_rng_memory side (drives all results)
//               Signals:
//                 request_seq   level, request generation and display
//                 request_Q     pulse, request a question symbol
//                 sequence_done sequence generated and fully shown
//                 rand_Q        question symbol        (DATA_W)
//                 q_valid       one-cycle pulse when rand_Q is updated
//                 q_idx         memory index of rand_Q (IDX_W)
//                 disp_en       a symbol is being shown
//                 disp_idx      position of the shown symbol (IDX_W)
//                 disp_val      shown symbol           (DATA_W)
// Revision    : 1.0 - initial release
// ============================================================================
interface sequence_rng_memory_if #(
    parameter int DATA_W = 3,
    parameter int IDX_W  = 3
);
    logic              request_seq;
    logic              request_Q;
    logic              sequence_done;
    logic [DATA_W-1:0] rand_Q;
    logic              q_valid;
    logic [IDX_W-1:0]  q_idx;
    logic              disp_en;
    logic [IDX_W-1:0]  disp_idx;
    logic [DATA_W-1:0] disp_val;

    modport master (
        output request_seq,
        output request_Q,
        input  sequence_done,
        input  rand_Q,
        input  q_valid,
        input  q_idx,
        input  disp_en,
        input  disp_idx,
        input  disp_val
    );

    modport slave (
        input  request_seq,
        input  request_Q,
        output sequence_done,
        output rand_Q,
        output q_valid,
        output q_idx,
        output disp_en,
        output disp_idx,
        output disp_val
    );
endinterface
`default_nettype wire

// File: rtl/sequence_rng_memory.sv
`default_nettype none
// ============================================================================
// Module      : sequence_rng_memory
// Description : Generates a SEQ_LEN-entry pseudo-random symbol sequence from a
//               free-running 16-bit Galois LFSR, stores it, shows it one
//               symbol at a time (SHOW_CYCLES cycles each) and then flags
//               sequence_done. On request_Q (in IDLE/DONE only) it returns a
//               pseudo-randomly chosen stored entry with 1-cycle latency.
//               Ports:
//                 clk  clock
//                 rst  synchronous reset, active low
//                 bus  sequence_rng_memory_if.slave (requests in, display and
//                      question results out); its DATA_W/IDX_W must match
//                      this module's parameters.
//               Parameter limits: 2 <= SEQ_LEN <= 8,
//               SEQ_LEN <= 2**IDX_W <= 2*SEQ_LEN, SHOW_CYCLES >= 1,
//               SEED != 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_rng_memory #(
    parameter int          SEQ_LEN     = 5,
    parameter int          DATA_W      = 3,
    parameter int          IDX_W       = 3,
    parameter int          SHOW_CYCLES = 50000000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    sequence_rng_memory_if.slave       bus
);

    // Memory is sized to the full index space so any IDX_W-bit index is
    // in range; only the first SEQ_LEN entries are ever written.
    localparam int                c_MEM_DEPTH   = 1 << IDX_W;
    localparam int                c_CNT_W       = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  c_LAST_IDX    = IDX_W'(SEQ_LEN - 1);
    localparam logic [IDX_W:0]    c_SEQ_LEN_EXT = (IDX_W + 1)'(SEQ_LEN);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(SHOW_CYCLES - 1);
    localparam logic [15:0]       c_LFSR_MASK   = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [c_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]   mem_q [c_MEM_DEPTH];

    logic                seq_done_q, seq_done_d;
    logic                disp_en_q, disp_en_d;
    logic [IDX_W-1:0]    disp_idx_q, disp_idx_d;
    logic [DATA_W-1:0]   disp_val_q, disp_val_d;
    logic [DATA_W-1:0]   rand_q_q, rand_q_d;
    logic [IDX_W-1:0]    q_idx_q, q_idx_d;
    logic                q_valid_q, q_valid_d;

    logic                w_mem_we;
    logic [IDX_W:0]      w_v_ext;
    logic [IDX_W-1:0]    w_pick_idx;

    // Fold the low LFSR bits into 0..SEQ_LEN-1. A single subtraction is
    // enough because 2**IDX_W never exceeds 2*SEQ_LEN.
    assign w_v_ext    = {1'b0, lfsr_q[IDX_W-1:0]};
    assign w_pick_idx = (w_v_ext < c_SEQ_LEN_EXT) ? lfsr_q[IDX_W-1:0]
                                                  : IDX_W'(w_v_ext - c_SEQ_LEN_EXT);

    // Galois LFSR, advances every cycle out of reset regardless of state.
    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_LFSR_MASK) : (lfsr_q >> 1);

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        hold_cnt_d = hold_cnt_q;
        seq_done_d = seq_done_q;
        disp_en_d  = disp_en_q;
        disp_idx_d = disp_idx_q;
        disp_val_d = disp_val_q;
        rand_q_d   = rand_q_q;
        q_idx_d    = q_idx_q;
        q_valid_d  = 1'b0;
        w_mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                seq_done_d = 1'b0;
                disp_en_d  = 1'b0;
                if (bus.request_seq) begin
                    state_d  = S_GEN;
                    wr_idx_d = '0;
                end
            end
            S_GEN: begin
                if (!bus.request_seq) begin
                    // Abort keeps whatever was already written.
                    state_d    = S_IDLE;
                    disp_en_d  = 1'b0;
                    seq_done_d = 1'b0;
                end else begin
                    w_mem_we = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == c_LAST_IDX) begin
                        // Entry 0 was written on the first GEN cycle.
                        state_d    = S_SHOW;
                        disp_idx_d = '0;
                        disp_val_d = mem_q[0];
                        disp_en_d  = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
            end
            S_SHOW: begin
                if (!bus.request_seq) begin
                    state_d    = S_IDLE;
                    disp_en_d  = 1'b0;
                    seq_done_d = 1'b0;
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (disp_idx_q == c_LAST_IDX) begin
                        state_d    = S_DONE;
                        disp_en_d  = 1'b0;
                        seq_done_d = 1'b1;
                    end else begin
                        disp_idx_d = disp_idx_q + IDX_W'(1);
                        disp_val_d = mem_q[disp_idx_q + IDX_W'(1)];
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + c_CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!bus.request_seq) begin
                    state_d    = S_IDLE;
                    seq_done_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Questions are only served while the memory is stable. A read in
        // the same IDLE cycle that starts GEN sees the old contents.
        if (((state_q == S_IDLE) || (state_q == S_DONE)) && bus.request_Q) begin
            q_valid_d = 1'b1;
            q_idx_d   = w_pick_idx;
            rand_q_d  = mem_q[w_pick_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            wr_idx_q   <= '0;
            hold_cnt_q <= '0;
            seq_done_q <= 1'b0;
            disp_en_q  <= 1'b0;
            disp_idx_q <= '0;
            disp_val_q <= '0;
            rand_q_q   <= '0;
            q_idx_q    <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            wr_idx_q   <= wr_idx_d;
            hold_cnt_q <= hold_cnt_d;
            seq_done_q <= seq_done_d;
            disp_en_q  <= disp_en_d;
            disp_idx_q <= disp_idx_d;
            disp_val_q <= disp_val_d;
            rand_q_q   <= rand_q_d;
            q_idx_q    <= q_idx_d;
            q_valid_q  <= q_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_mem_we) begin
            mem_q[wr_idx_q] <= lfsr_q[DATA_W-1:0];
        end
    end

    assign bus.sequence_done = seq_done_q;
    assign bus.disp_en       = disp_en_q;
    assign bus.disp_idx      = disp_idx_q;
    assign bus.disp_val      = disp_val_q;
    assign bus.rand_Q        = rand_q_q;
    assign bus.q_idx         = q_idx_q;
    assign bus.q_valid       = q_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_rng_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequence_rng_memory
// Description : Directed self-checking bench for sequence_rng_memory with
//               SEQ_LEN=5, SHOW_CYCLES=4. Expected memory contents come from
//               a reference LFSR that runs alongside the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_rng_memory;

    localparam int          SEQ_LEN     = 5;
    localparam int          DATA_W      = 3;
    localparam int          IDX_W       = 3;
    localparam int          SHOW_CYCLES = 4;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic clk;
    logic rst;

    sequence_rng_memory_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    sequence_rng_memory #(
        .SEQ_LEN    (SEQ_LEN),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .SHOW_CYCLES(SHOW_CYCLES),
        .SEED       (SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int              n_cmp;
    int              n_err;
    logic [15:0]     m_lfsr;
    logic [2:0]      exp_mem [SEQ_LEN];
    int              exp_qidx;
    logic [2:0]      exp_rand;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Galois LFSR: mask 16'hB400 applied when the lsb shifts out.
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [15:0] l);
        int v;
        v = int'(l[2:0]);
        return (v < SEQ_LEN) ? v : v - SEQ_LEN;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},   16'(bus.sequence_done), 16'h0);
        check({tag, "_rand"},   16'(bus.rand_Q),        16'h0);
        check({tag, "_qvalid"}, 16'(bus.q_valid),       16'h0);
        check({tag, "_qidx"},   16'(bus.q_idx),         16'h0);
        check({tag, "_den"},    16'(bus.disp_en),       16'h0);
        check({tag, "_didx"},   16'(bus.disp_idx),      16'h0);
        check({tag, "_dval"},   16'(bus.disp_val),      16'h0);
        check({tag, "_lfsr"},   dut.lfsr_q,             16'hACE1);
        for (int k = 0; k < SEQ_LEN; k++)
            check({tag, "_mem"}, 16'(dut.mem_q[k]), 16'h0);
    endtask

    // Called at the negedge after the edge that entered GEN. Records what
    // each GEN edge must write; optionally pulses request_Q on one of them.
    task automatic gen_phase(input int pulse_at);
        for (int k = 0; k < SEQ_LEN; k++) begin
            exp_mem[k] = m_lfsr[2:0];
            check("gen_den", 16'(bus.disp_en), 16'h0);
            if (k == pulse_at) bus.request_Q = 1'b1;
            tick();
            bus.request_Q = 1'b0;
            if (k == pulse_at) begin
                check("gen_q_qvalid", 16'(bus.q_valid), 16'h0);
                check("gen_q_qidx",   16'(bus.q_idx),   16'(exp_qidx));
                check("gen_q_rand",   16'(bus.rand_Q),  16'(exp_rand));
            end
        end
        for (int k = 0; k < SEQ_LEN; k++)
            check("gen_mem", 16'(dut.mem_q[k]), 16'(exp_mem[k]));
    endtask

    // Called at the first negedge of SHOW. abort_d drops request_seq at the
    // start of that symbol; pulse_d pulses request_Q during that symbol.
    task automatic show_phase(input int abort_d, input int pulse_d);
        for (int d = 0; d < SEQ_LEN; d++) begin
            for (int c = 0; c < SHOW_CYCLES; c++) begin
                check("show_den",  16'(bus.disp_en),       16'h1);
                check("show_didx", 16'(bus.disp_idx),      16'(d));
                check("show_dval", 16'(bus.disp_val),      16'(exp_mem[d]));
                check("show_done", 16'(bus.sequence_done), 16'h0);
                if (d == abort_d && c == 0) begin
                    bus.request_seq = 1'b0;
                    tick();
                    check("abort_den",  16'(bus.disp_en),       16'h0);
                    check("abort_done", 16'(bus.sequence_done), 16'h0);
                    return;
                end
                if (d == pulse_d && c == 1) bus.request_Q = 1'b1;
                tick();
                bus.request_Q = 1'b0;
                if (d == pulse_d && c == 1) begin
                    check("show_q_qvalid", 16'(bus.q_valid), 16'h0);
                    check("show_q_qidx",   16'(bus.q_idx),   16'(exp_qidx));
                    check("show_q_rand",   16'(bus.rand_Q),  16'(exp_rand));
                end
            end
        end
    endtask

    // Pulse request_Q for one sampled edge and check the served question.
    task automatic ask(input string tag);
        exp_qidx = pick(m_lfsr);
        exp_rand = exp_mem[exp_qidx];
        bus.request_Q = 1'b1;
        tick();
        bus.request_Q = 1'b0;
        check({tag, "_qvalid"}, 16'(bus.q_valid), 16'h1);
        check({tag, "_qidx"},   16'(bus.q_idx),   16'(exp_qidx));
        check({tag, "_rand"},   16'(bus.rand_Q),  16'(exp_rand));
        tick();
        check({tag, "_qvalid_drop"}, 16'(bus.q_valid), 16'h0);
        check({tag, "_qidx_hold"},   16'(bus.q_idx),   16'(exp_qidx));
        check({tag, "_rand_hold"},   16'(bus.rand_Q),  16'(exp_rand));
    endtask

    initial begin
        bit          found;
        logic [2:0]  old_mem [SEQ_LEN];

        n_cmp = 0;
        n_err = 0;
        exp_qidx = 0;
        exp_rand = '0;
        rst = 1'b0;
        bus.request_seq = 1'b0;
        bus.request_Q   = 1'b0;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) tick();

        // Full generate + show, request_seq held
        bus.request_seq = 1'b1;
        tick();
        gen_phase(-1);
        show_phase(-1, -1);
        check("done_rise", 16'(bus.sequence_done), 16'h1);
        check("done_den",  16'(bus.disp_en),       16'h0);

        // Question in DONE
        ask("q_done");
        check("q_done_still", 16'(bus.sequence_done), 16'h1);

        // Wrap case: low LFSR bits 6 must fold to index 1
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_lfsr[2:0] == 3'd6) found = 1'b1;
            else tick();
        end
        check("wrap_found", 16'(found), 16'h1);
        bus.request_Q = 1'b1;
        tick();
        bus.request_Q = 1'b0;
        exp_qidx = 1;
        exp_rand = exp_mem[1];
        check("wrap_qvalid", 16'(bus.q_valid), 16'h1);
        check("wrap_qidx",   16'(bus.q_idx),   16'h1);
        check("wrap_rand",   16'(bus.rand_Q),  16'(exp_mem[1]));

        // Drop request_seq in DONE
        bus.request_seq = 1'b0;
        tick();
        check("drop_done", 16'(bus.sequence_done), 16'h0);
        tick();

        // request_Q ignored in GEN and SHOW; abort at disp_idx 2
        bus.request_seq = 1'b1;
        tick();
        gen_phase(2);
        show_phase(2, 1);
        for (int i = 0; i < 30; i++) begin
            check("abort_no_done", 16'(bus.sequence_done), 16'h0);
            tick();
        end

        // Re-request regenerates every entry, then abort straight away
        bus.request_seq = 1'b1;
        tick();
        gen_phase(-1);
        show_phase(0, -1);
        tick();

        // Simultaneous request_seq + request_Q in IDLE: old contents returned
        for (int k = 0; k < SEQ_LEN; k++) old_mem[k] = exp_mem[k];
        exp_qidx = pick(m_lfsr);
        exp_rand = old_mem[exp_qidx];
        bus.request_seq = 1'b1;
        bus.request_Q   = 1'b1;
        tick();
        bus.request_Q = 1'b0;
        check("simul_qvalid", 16'(bus.q_valid), 16'h1);
        check("simul_qidx",   16'(bus.q_idx),   16'(exp_qidx));
        check("simul_rand",   16'(bus.rand_Q),  16'(exp_rand));
        gen_phase(-1);
        check("simul_show_den", 16'(bus.disp_en), 16'h1);

        // Reset held 3 cycles mid-SHOW
        repeat (6) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_all_zero("midrst");
        rst = 1'b1;
        bus.request_seq = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
